// File: rtl/fully_connected_layer.sv
// +--------------------------------------------------------------------------+
// | fully_connected_layer: sequential dense stage, one signed MAC per clock,  |
// | saturating output with optional ReLU (macro FC_RELU_EN). Rev 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

module fully_connected_layer #(
    parameter int SIZEIN    = 15,
    parameter int NEURONS   = 10,
    parameter int WIDTH_BIT = 16,
    parameter int FRAC_BIT  = 8
) (
    input  logic                                                   clock,
    input  logic                                                   nreset,
    input  logic                                                   start,
    input  logic [SIZEIN-1:0][SIZEIN-1:0][WIDTH_BIT-1:0]           featureIn,
    input  logic [NEURONS-1:0][SIZEIN*SIZEIN-1:0][WIDTH_BIT-1:0]   weights,
    input  logic [NEURONS-1:0][WIDTH_BIT-1:0]                      bias,
    output logic [NEURONS-1:0][WIDTH_BIT-1:0]                      fcOut,
    output logic                                                   busy,
    output logic                                                   done
);

    localparam int N  = SIZEIN * SIZEIN;
    localparam int PW = 2 * WIDTH_BIT;
    localparam int AW = 2 * WIDTH_BIT + $clog2(N) + 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NEURONS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, MAC, STORE} state_t;

    state_t state, state_next;

    logic [KW-1:0]               k;
    logic [NW-1:0]               n;
    logic signed [AW-1:0]        acc;
    logic [N-1:0][WIDTH_BIT-1:0] feat_vec;
    logic signed [PW-1:0]        feat_ext, weight_ext, prod;
    logic signed [AW-1:0]        prod_ext, bias_ext, shifted;
    logic [AW-WIDTH_BIT:0]       upper;
    logic [WIDTH_BIT-1:0]        sat, result;

    // Row-major flattening: element (i,j) lands at index i*SIZEIN+j
    assign feat_vec   = featureIn;
    assign feat_ext   = PW'($signed(feat_vec[k]));
    assign weight_ext = PW'($signed(weights[n][k]));
    assign prod       = feat_ext * weight_ext;
    assign prod_ext   = AW'(prod);
    assign bias_ext   = AW'($signed(bias[n])) <<< FRAC_BIT;
    assign shifted    = acc >>> FRAC_BIT;
    assign upper      = shifted[AW-1:WIDTH_BIT-1];

    always_comb begin
        sat = shifted[WIDTH_BIT-1:0];
        // Out of range whenever the bits above the output sign differ from it
        if (!((&upper) || (~|upper))) begin
            sat = shifted[AW-1] ? {1'b1, {(WIDTH_BIT-1){1'b0}}}
                                : {1'b0, {(WIDTH_BIT-1){1'b1}}};
        end
`ifdef FC_RELU_EN
        result = sat[WIDTH_BIT-1] ? '0 : sat;
`else
        result = sat;
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = MAC;
            MAC:     if (k == K_LAST) state_next = STORE;
            STORE:   state_next = (n == N_LAST) ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            acc   <= '0;
            n     <= '0;
            k     <= '0;
            fcOut <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    n <= '0;
                    k <= '0;
                end
                LOAD: begin
                    acc <= bias_ext;
                    k   <= '0;
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    k   <= k + 1'b1;
                end
                STORE: begin
                    fcOut[n] <= result;
                    if (n == N_LAST) begin
                        n    <= '0;
                        done <= 1'b1;
                    end else begin
                        n <= n + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fully_connected_layer.sv
// Directed, table-driven bench for fully_connected_layer (SIZEIN=2, NEURONS=2).
`default_nettype none

module tb_fully_connected_layer;

    localparam int SIZEIN = 2;
    localparam int NEURONS = 2;
    localparam int W = 16;
    localparam int FB = 8;
    localparam int LAT = 12;

    logic clock = 1'b0;
    logic nreset = 1'b0;
    logic start = 1'b0;
    logic [SIZEIN-1:0][SIZEIN-1:0][W-1:0] feature_in = '0;
    logic [NEURONS-1:0][3:0][W-1:0] weights = '0;
    logic [NEURONS-1:0][W-1:0] bias = '0;
    logic [NEURONS-1:0][W-1:0] fc_out;
    logic busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    fully_connected_layer #(
        .SIZEIN(SIZEIN), .NEURONS(NEURONS), .WIDTH_BIT(W), .FRAC_BIT(FB)
    ) dut (
        .clock(clock), .nreset(nreset), .start(start),
        .featureIn(feature_in), .weights(weights), .bias(bias),
        .fcOut(fc_out), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0][W-1:0] feat;
        logic [3:0][W-1:0] w0;
        logic [3:0][W-1:0] w1;
        logic [W-1:0] b0;
        logic [W-1:0] b1;
        logic [W-1:0] e0;   // expected before any ReLU
        logic [W-1:0] e1;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [3:0][W-1:0] mk4(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][W-1:0] r;
        r[0] = W'(a0); r[1] = W'(a1); r[2] = W'(a2); r[3] = W'(a3);
        return r;
    endfunction

    function automatic int relu(input logic [W-1:0] x);
        int v;
        v = int'($signed(x));
`ifdef FC_RELU_EN
        if (v < 0) v = 0;
`endif
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        feature_in = v.feat;
        weights = {v.w1, v.w0};
        bias = {v.b1, v.b0};
    endtask

    // Runs one computation; cyc counts negedges after the start-sampling edge
    task automatic run_op(input bit prestarted, input bit extra, input bit chain,
                          output int lat, output int bcnt, output int f6, output int f7);
        int cyc;
        bit seen;
        if (!prestarted) begin
            @(negedge clock);
            start = 1'b1;
        end
        @(negedge clock);
        start = 1'b0;
        cyc = 1; bcnt = 0; f6 = 0; f7 = 0; seen = 0;
        while (!seen && cyc < 60) begin
            if (busy) bcnt++;
            if (cyc == 6) f6 = int'($signed(fc_out[0]));
            if (cyc == 7) f7 = int'($signed(fc_out[0]));
            if (done) begin
                seen = 1;
            end else begin
                start = extra && (cyc == 3 || cyc == 7);
                @(negedge clock);
                cyc++;
            end
        end
        lat = seen ? cyc - 1 : -1;
        start = chain && seen;
    endtask

    initial begin
        int lat, bcnt, f6, f7, prev0, extra_done;

        vecs[0] = '{feat: mk4(256, 256, 256, 256), w0: mk4(128, 128, 128, 128),
                    w1: mk4(-256, -256, -256, -256), b0: 16'(64), b1: 16'(0),
                    e0: 16'(576), e1: 16'(-1024)};
        vecs[1] = '{feat: mk4(32512, 32512, 32512, 32512), w0: mk4(32512, 32512, 32512, 32512),
                    w1: mk4(-32512, -32512, -32512, -32512), b0: 16'(0), b1: 16'(0),
                    e0: 16'(32767), e1: 16'(-32768)};
        vecs[2] = '{feat: mk4(1, 0, 0, 0), w0: mk4(1, 0, 0, 0), w1: mk4(-1, 0, 0, 0),
                    b0: 16'(0), b1: 16'(0), e0: 16'(0), e1: 16'(-1)};
        vecs[3] = '{feat: mk4(256, -512, 768, 0), w0: mk4(256, 256, 256, 256),
                    w1: mk4(0, 0, 0, 0), b0: 16'(-100), b1: 16'(-3),
                    e0: 16'(412), e1: 16'(-3)};
        vecs[4] = '{feat: mk4(300, 100, -50, 10), w0: mk4(-7, 0, 0, 0),
                    w1: mk4(5, 5, 5, 5), b0: 16'(0), b1: 16'(1),
                    e0: 16'(-9), e1: 16'(8)};

        repeat (3) @(negedge clock);
        check("reset_fc0", int'($signed(fc_out[0])), 0);
        check("reset_fc1", int'($signed(fc_out[1])), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        nreset = 1'b1;

        prev0 = 0;
        for (int i = 0; i < 5; i++) begin
            apply(vecs[i]);
            run_op(1'b0, 1'b0, 1'b0, lat, bcnt, f6, f7);
            check($sformatf("v%0d_latency", i), lat, LAT);
            check($sformatf("v%0d_busy_cycles", i), bcnt, LAT);
            check($sformatf("v%0d_fc0_hold", i), f6, prev0);
            check($sformatf("v%0d_fc0_write", i), f7, relu(vecs[i].e0));
            check($sformatf("v%0d_fc0", i), int'($signed(fc_out[0])), relu(vecs[i].e0));
            check($sformatf("v%0d_fc1", i), int'($signed(fc_out[1])), relu(vecs[i].e1));
            prev0 = relu(vecs[i].e0);
        end

        // Starts while busy are ignored; a start in the done cycle chains immediately
        apply(vecs[0]);
        run_op(1'b0, 1'b1, 1'b1, lat, bcnt, f6, f7);
        check("hs_first_latency", lat, LAT);
        apply(vecs[3]);
        run_op(1'b1, 1'b0, 1'b0, lat, bcnt, f6, f7);
        check("hs_chained_latency", lat, LAT);
        check("hs_chained_fc0", int'($signed(fc_out[0])), relu(vecs[3].e0));
        check("hs_chained_fc1", int'($signed(fc_out[1])), relu(vecs[3].e1));
        extra_done = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) extra_done++;
        end
        check("hs_no_extra_done", extra_done, 0);

        // Asynchronous reset in the middle of a computation
        apply(vecs[4]);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        nreset = 1'b0;
        #1;
        check("mid_reset_fc0", int'($signed(fc_out[0])), 0);
        check("mid_reset_fc1", int'($signed(fc_out[1])), 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_done", int'(done), 0);
        @(negedge clock);
        nreset = 1'b1;
        run_op(1'b0, 1'b0, 1'b0, lat, bcnt, f6, f7);
        check("post_reset_latency", lat, LAT);
        check("post_reset_fc0_hold", f6, 0);
        check("post_reset_fc0", int'($signed(fc_out[0])), relu(vecs[4].e0));
        check("post_reset_fc1", int'($signed(fc_out[1])), relu(vecs[4].e1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fully_connected_layer.md
# fully_connected_layer

Sequential dense (fully connected) stage that sits directly downstream of the max-pooling stage. It consumes the pooled feature matrix once that stage signals completion. It computes NEURONS signed fixed-point dot products, one multiply-accumulate per clock, and presents each result with saturation and an optional ReLU. It provides the classifier outputs of the network.

## Interface
Parameters:
- SIZEIN, 15: side of the square pooled input matrix; N = SIZEIN*SIZEIN inputs per neuron
- NEURONS, 10: number of output neurons
- WIDTH_BIT, 16: width of every data word (features, weights, bias, outputs), two's complement
- FRAC_BIT, 8: fractional bits of the fixed-point format, shared by all data words

Ports:
- clock  input  1  rising-edge clock
- nreset  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request; driven by the pooling stage's done
- featureIn  input  signed [WIDTH_BIT-1:0] [SIZEIN-1:0][SIZEIN-1:0]  pooled matrix; must stay stable from start until done
- weights  input  signed [WIDTH_BIT-1:0] [NEURONS-1:0][N-1:0]  per-neuron weights, row-major index k = i*SIZEIN+j
- bias  input  signed [WIDTH_BIT-1:0] [NEURONS-1:0]  per-neuron bias
- fcOut  output  signed [WIDTH_BIT-1:0] [NEURONS-1:0]  registered neuron results
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse when all neurons are written

## Operation
- FSM states: IDLE, LOAD, MAC, STORE.
- IDLE: start=1 moves to LOAD. Neuron index n and element index k are cleared.
- LOAD: acc <= sign-extended bias[n] << FRAC_BIT; k <= 0; then MAC.
- MAC: acc <= acc + featureIn[k/SIZEIN][k%SIZEIN] * weights[n][k]. This is a full 2*WIDTH_BIT signed product. After k = N-1 the FSM goes to STORE.
- acc width: 2*WIDTH_BIT + $clog2(N) + 1. It never overflows.
- STORE: r = acc >>> FRAC_BIT (arithmetic shift, truncation toward -inf). r saturates to [-2^(WIDTH_BIT-1), 2^(WIDTH_BIT-1)-1]. ReLU is applied per Configuration. The result is written to fcOut[n].
- After STORE: if n < NEURONS-1, n++ and go to LOAD. Otherwise go to IDLE, and done=1 for that one cycle.
- fcOut[n] keeps its old value until its own STORE. All other entries are untouched.
- start while busy=1 is ignored; no queueing.
- Reset (async, any state): FSM=IDLE, acc=0, n=k=0, fcOut all 0, busy=0, done=0. A computation in progress is abandoned, and partially written fcOut entries are cleared.

## Timing
- Edge E0 samples start=1 in IDLE.
- busy rises after E0.
- Each neuron takes N+2 cycles: LOAD, N MAC cycles, STORE.
- fcOut[n] updates on edge E0 + (n+1)*(N+2).
- done and the fall of busy both occur on edge E0 + NEURONS*(N+2). done is held exactly one cycle.
- FSM is in IDLE during the done cycle, so a start sampled then is accepted: back-to-back operation with no gap.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- FC_RELU_EN defined: STORE writes max(r_sat, 0), so negative results become 0.
- FC_RELU_EN undefined: STORE writes r_sat unchanged, including negatives.
- Latency is identical in both builds.

## Test plan
Bench parameters: SIZEIN=2, NEURONS=2, WIDTH_BIT=16, FRAC_BIT=8, giving N=4 and a latency of 12 cycles.
- Basic dot product: featureIn all 256 (1.0), weights[0] all 128 (0.5), bias[0]=64 -> fcOut[0]=576 (2.25), written on E0+6; done on E0+12; busy high for exactly 12 cycles.
- Negative result: weights[1] all -256, bias[1]=0 -> fcOut[1]=-1024 without FC_RELU_EN; fcOut[1]=0 with FC_RELU_EN.
- Saturation: featureIn all 32512, weights all 32512, bias 0 -> fcOut=32767. With all weights -32512 -> fcOut=-32768 without ReLU.
- Truncation: one feature 1, its weight 1, all other terms 0, bias 0 -> acc=1, fcOut=0. With that weight -1 -> fcOut=-1 (floor), without ReLU.
- Handshake: start pulsed again at cycles 3 and 7 while busy -> exactly one done. A start during the done cycle -> second done 12 cycles later.
- Reset mid-operation: nreset low at cycle 5 -> fcOut all 0, busy=0, done=0 immediately. After release, a new start produces correct results on the normal schedule.
